// File: rtl/spi_init_pkg.sv
// Shared constants and word classification for the LCD init-ROM SPI receiver.
package spi_init_pkg;

   localparam int WORD_BITS = 16;
   localparam int ROM_BITS  = 9;
   localparam int END_BIT   = 15;
   localparam logic [WORD_BITS-1:0] MAGIC_WORD = 16'hCAFE;

   typedef enum logic [1:0] {
      WORD_DATA,
      WORD_END,
      WORD_MAGIC
   } word_class_t;

   // The magic test word wins over the end marker, even though it has bit 15 set.
   function automatic word_class_t classify_word(input logic [WORD_BITS-1:0] word);
      if (word == MAGIC_WORD) begin
         return WORD_MAGIC;
      end else if (word[END_BIT]) begin
         return WORD_END;
      end
      return WORD_DATA;
   endfunction

endpackage

// File: rtl/spi_init_rx_if.sv
// Ready/ack handshake carrying init words from the SPI receiver to the lcd block.
import spi_init_pkg::*;

interface spi_init_rx_if;
   logic [ROM_BITS-1:0] rom;
   logic                rdy;
   logic                ack;

   modport master (output rom, output rdy, input ack);
   modport slave  (input rom, input rdy, output ack);
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with RAM-style storage and a registered read port.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [WIDTH-1:0] dout_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push = i_push && (count_reg != FULL_COUNT);
   assign do_pop  = i_pop && (count_reg != '0);

   // Storage array written without reset so it maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= i_din;
      end
   end

   // Registered read: the popped word appears on o_dout the cycle after the pop.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         dout_reg <= '0;
      end else if (do_pop) begin
         dout_reg <= mem[rd_ptr_reg];
      end
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign o_dout  = dout_reg;
   assign o_full  = (count_reg == FULL_COUNT);
   assign o_empty = (count_reg == '0);
   assign o_count = count_reg;

endmodule

// File: rtl/spi_init_rx.sv
// Oversampled SPI mode-0 slave receiving the LCD init-ROM stream, with a word
// FIFO and a ready/ack output register towards the lcd block.
import spi_init_pkg::*;

module spi_init_rx #(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2   // must be at least 2
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_spi_clk,
   input  logic               i_spi_mosi,
   input  logic               i_spi_cs,
   output logic               o_spi_miso,
   output logic               o_spi_miso_oe,
   spi_init_rx_if.master      init,
   output logic               o_init_done,
   output logic               o_magic,
   output logic               o_overflow
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [SYNC_STAGES-1:0] sclk_sync_reg;
   logic [SYNC_STAGES-1:0] mosi_sync_reg;
   logic [SYNC_STAGES-1:0] cs_sync_reg;
   logic [SYNC_STAGES-1:0] cs_valid_reg;
   logic                   sclk_s, mosi_s, cs_s;
   logic                   sclk_prev_reg, cs_prev_reg;
   logic                   armed_reg, frame_reg;
   logic [3:0]             bit_cnt_reg;
   logic [WORD_BITS-1:0]   rx_shift_reg, rx_last_reg, tx_reg;
   logic [WORD_BITS-1:0]   rx_next;
   logic                   sclk_rise, sclk_fall, frame_start, word_done;
   word_class_t            word_class;
   logic                   push_req, buffer_full, fifo_push;
   logic                   end_seen_reg, magic_reg, overflow_reg, done_reg;
   logic                   rdy_reg, rdy_next, pop;
   logic [ROM_BITS-1:0]    fifo_dout;
   logic                   fifo_full, fifo_empty;
   logic [CW-1:0]          fifo_count;

   // Synchronizer chains. CS resets to its idle (high) level so the output
   // enable is low out of reset; cs_valid marks when the chain holds real samples.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sclk_sync_reg <= '0;
         mosi_sync_reg <= '0;
         cs_sync_reg   <= '1;
         cs_valid_reg  <= '0;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], i_spi_clk};
         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], i_spi_mosi};
         cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], i_spi_cs};
         cs_valid_reg  <= {cs_valid_reg[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];
   assign cs_s   = cs_sync_reg[SYNC_STAGES-1];

   // A frame only starts on a genuine CS falling edge seen after CS was
   // observed high, so a reset in mid-frame waits for the next frame.
   assign frame_start = cs_prev_reg && !cs_s && armed_reg;
   assign sclk_rise   = sclk_s && !sclk_prev_reg && frame_reg && !cs_s;
   assign sclk_fall   = !sclk_s && sclk_prev_reg && frame_reg && !cs_s;
   assign rx_next     = {rx_shift_reg[WORD_BITS-2:0], mosi_s};
   assign word_done   = sclk_rise && (bit_cnt_reg == 4'hF);

   // Bit capture, frame tracking and the MISO echo register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sclk_prev_reg <= 1'b0;
         cs_prev_reg   <= 1'b1;
         armed_reg     <= 1'b0;
         frame_reg     <= 1'b0;
         bit_cnt_reg   <= '0;
         rx_shift_reg  <= '0;
         rx_last_reg   <= '0;
         tx_reg        <= '0;
      end else begin
         sclk_prev_reg <= sclk_s;
         cs_prev_reg   <= cs_s;
         if (cs_valid_reg[SYNC_STAGES-1] && cs_s) begin
            armed_reg <= 1'b1;
         end
         if (cs_s) begin
            frame_reg    <= 1'b0;
            bit_cnt_reg  <= '0;
            rx_shift_reg <= '0;
         end else if (frame_start) begin
            frame_reg <= 1'b1;
         end else if (sclk_rise) begin
            rx_shift_reg <= rx_next;
            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
            if (word_done) begin
               rx_last_reg <= rx_next;
            end
         end
         if (frame_start) begin
            tx_reg <= rx_last_reg;
         end else if (word_done) begin
            tx_reg <= rx_next;
         end else if (sclk_fall) begin
            tx_reg <= {tx_reg[WORD_BITS-2:0], 1'b0};
         end
      end
   end

   // Classify each completed word; the presented output word counts against
   // the buffer depth so at most FIFO_DEPTH words are ever held.
   always_comb begin
      word_class  = classify_word(rx_next);
      push_req    = word_done && (word_class == WORD_DATA) && !end_seen_reg;
      buffer_full = fifo_full || ((fifo_count + CW'(rdy_reg)) >= CW'(FIFO_DEPTH));
      fifo_push   = push_req && !buffer_full;
   end

   // Output register handshake: refill when empty or when the word is taken.
   always_comb begin
      pop      = !fifo_empty && (!rdy_reg || init.ack);
      rdy_next = rdy_reg;
      if (pop) begin
         rdy_next = 1'b1;
      end else if (init.ack) begin
         rdy_next = 1'b0;
      end
   end

   // Sticky status flags and the ready register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         end_seen_reg <= 1'b0;
         magic_reg    <= 1'b0;
         overflow_reg <= 1'b0;
         done_reg     <= 1'b0;
         rdy_reg      <= 1'b0;
      end else begin
         rdy_reg <= rdy_next;
         if (word_done && (word_class == WORD_MAGIC)) begin
            magic_reg <= 1'b1;
         end
         if (word_done && (word_class == WORD_END)) begin
            end_seen_reg <= 1'b1;
         end
         if (push_req && buffer_full) begin
            overflow_reg <= 1'b1;
         end
         if (end_seen_reg && fifo_empty && !rdy_next) begin
            done_reg <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (ROM_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (fifo_push),
      .i_din   (rx_next[ROM_BITS-1:0]),
      .i_pop   (pop),
      .o_dout  (fifo_dout),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_count)
   );

   assign init.rom      = fifo_dout;
   assign init.rdy      = rdy_reg;
   assign o_spi_miso    = tx_reg[WORD_BITS-1];
   assign o_spi_miso_oe = !cs_s;
   assign o_init_done   = done_reg;
   assign o_magic       = magic_reg;
   assign o_overflow    = overflow_reg;

endmodule

// File: tb/tb_spi_init_rx.sv
// Directed bench for spi_init_rx: SPI frames bit-banged at i_clk/12.
module tb_spi_init_rx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclk = 1'b0;
   logic mosi = 1'b0;
   logic cs = 1'b1;
   logic miso, miso_oe, done, magic, overflow;
   int   checks = 0;
   int   failures = 0;

   spi_init_rx_if init_bus ();

   spi_init_rx #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_spi_clk     (sclk),
      .i_spi_mosi    (mosi),
      .i_spi_cs      (cs),
      .o_spi_miso    (miso),
      .o_spi_miso_oe (miso_oe),
      .init          (init_bus),
      .o_init_done   (done),
      .o_magic       (magic),
      .o_overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; init_bus.ack = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic cs_low();
      cs = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (6) @(negedge clk);
      cs = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Sends the top nbits of w MSB first; MISO is sampled just before each rising edge.
   task automatic spi_send(input logic [15:0] w, input int nbits, output logic [15:0] mbits);
      mbits = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi = w[15-i];
         repeat (6) @(negedge clk);
         mbits[15-i] = miso;
         sclk = 1'b1;
         repeat (6) @(negedge clk);
         sclk = 1'b0;
      end
      mosi = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 5;
      if (init_bus.rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got %b want 0", init_bus.rdy); end
      if (init_bus.rom !== 9'h000) begin failures++; $display("FAIL reset_rom got %h want 000", init_bus.rom); end
      if ({done, magic, overflow} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b want 000", {done, magic, overflow}); end
      if (miso !== 1'b0) begin failures++; $display("FAIL reset_miso got %b want 0", miso); end
      if (miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got %b want 0", miso_oe); end
   endtask

   task automatic test_single_word();
      logic [15:0] mb;
      do_reset();
      cs_low();
      checks++;
      if (miso_oe !== 1'b1) begin failures++; $display("FAIL single_oe got %b want 1", miso_oe); end
      spi_send(16'h0123, 16, mb);
      cs_high();
      for (int k = 0; k < 200 && init_bus.rdy !== 1'b1; k++) @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (init_bus.rdy !== 1'b1 || init_bus.rom !== 9'h123) begin
            failures++; $display("FAIL single_hold cycle %0d got rdy=%b rom=%h want rdy=1 rom=123", c, init_bus.rdy, init_bus.rom);
         end
         @(negedge clk);
      end
      init_bus.ack = 1'b1;
      @(negedge clk);
      init_bus.ack = 1'b0;
      checks++;
      if (init_bus.rdy !== 1'b0) begin failures++; $display("FAIL single_ack_clear got rdy=%b want 0", init_bus.rdy); end
   endtask

   task automatic test_end_of_rom();
      logic [15:0] mb;
      logic [8:0]  exp_rom [3];
      exp_rom[0] = 9'h011; exp_rom[1] = 9'h122; exp_rom[2] = 9'h033;
      do_reset();
      cs_low();
      spi_send(16'h0011, 16, mb);
      spi_send(16'h0122, 16, mb);
      spi_send(16'h0033, 16, mb);
      spi_send(16'h8000, 16, mb);
      cs_high();
      repeat (20) @(negedge clk);
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL end_done_early got %b want 0", done); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (init_bus.rdy !== 1'b1 || init_bus.rom !== exp_rom[i]) begin
            failures++; $display("FAIL end_word%0d got rdy=%b rom=%h want rdy=1 rom=%h", i, init_bus.rdy, init_bus.rom, exp_rom[i]);
         end
         checks++;
         if (done !== 1'b0) begin failures++; $display("FAIL end_done_before_ack%0d got %b want 0", i, done); end
         init_bus.ack = 1'b1;
         @(negedge clk);
         init_bus.ack = 1'b0;
      end
      checks++;
      if (done !== 1'b1 || init_bus.rdy !== 1'b0) begin
         failures++; $display("FAIL end_done got done=%b rdy=%b want done=1 rdy=0", done, init_bus.rdy);
      end
   endtask

   task automatic test_magic();
      logic [15:0] mb;
      do_reset();
      cs_low();
      spi_send(16'hCAFE, 16, mb);
      cs_high();
      repeat (20) @(negedge clk);
      checks++;
      if ({magic, init_bus.rdy, done} !== 3'b100) begin
         failures++; $display("FAIL magic_flags got magic=%b rdy=%b done=%b want 1 0 0", magic, init_bus.rdy, done);
      end
      cs_low();
      spi_send(16'h0000, 16, mb);
      cs_high();
      checks++;
      if (mb !== 16'hCAFE) begin failures++; $display("FAIL magic_miso got %h want cafe", mb); end
   endtask

   task automatic test_overflow();
      logic [15:0] mb;
      do_reset();
      cs_low();
      for (int i = 1; i <= 9; i++) spi_send(16'h0100 | 16'(i), 16, mb);
      cs_high();
      repeat (20) @(negedge clk);
      checks++;
      if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got %b want 1", overflow); end
      for (int i = 1; i <= 8; i++) begin
         checks++;
         if (init_bus.rdy !== 1'b1 || init_bus.rom !== (9'h100 | 9'(i))) begin
            failures++; $display("FAIL ovf_word%0d got rdy=%b rom=%h want rdy=1 rom=%h", i, init_bus.rdy, init_bus.rom, 9'h100 | 9'(i));
         end
         init_bus.ack = 1'b1;
         @(negedge clk);
         init_bus.ack = 1'b0;
      end
      repeat (5) @(negedge clk);
      checks++;
      if (init_bus.rdy !== 1'b0) begin failures++; $display("FAIL ovf_word9_absent got rdy=%b rom=%h want rdy=0", init_bus.rdy, init_bus.rom); end
   endtask

   task automatic test_partial_word();
      logic [15:0] mb;
      do_reset();
      cs_low();
      spi_send(16'hFFFF, 7, mb);
      cs_high();
      cs_low();
      spi_send(16'h00AA, 16, mb);
      cs_high();
      for (int k = 0; k < 200 && init_bus.rdy !== 1'b1; k++) @(negedge clk);
      checks++;
      if (init_bus.rdy !== 1'b1 || init_bus.rom !== 9'h0AA) begin
         failures++; $display("FAIL partial_word got rdy=%b rom=%h want rdy=1 rom=0aa", init_bus.rdy, init_bus.rom);
      end
      init_bus.ack = 1'b1;
      @(negedge clk);
      init_bus.ack = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if (init_bus.rdy !== 1'b0) begin failures++; $display("FAIL partial_extra got rdy=%b want 0", init_bus.rdy); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] mb;
      do_reset();
      cs_low();
      spi_send(16'h0001, 16, mb);
      spi_send(16'h0002, 16, mb);
      spi_send(16'h0003, 16, mb);
      cs_high();
      repeat (10) @(negedge clk);
      init_bus.ack = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         checks++;
         if (init_bus.rdy !== 1'b1 || init_bus.rom !== 9'(i)) begin
            failures++; $display("FAIL b2b_word%0d got rdy=%b rom=%h want rdy=1 rom=%h", i, init_bus.rdy, init_bus.rom, 9'(i));
         end
         @(negedge clk);
      end
      init_bus.ack = 1'b0;
      checks++;
      if (init_bus.rdy !== 1'b0) begin failures++; $display("FAIL b2b_drain got rdy=%b want 0", init_bus.rdy); end
   endtask

   task automatic test_reset_mid_word();
      logic [15:0] mb;
      do_reset();
      cs_low();
      spi_send(16'hCAFE, 16, mb);
      spi_send(16'h0011, 16, mb);
      spi_send(16'h0022, 16, mb);
      spi_send(16'h0F00, 5, mb);
      repeat (10) @(negedge clk);
      checks++;
      if (magic !== 1'b1 || init_bus.rdy !== 1'b1) begin
         failures++; $display("FAIL rstmid_pre got magic=%b rdy=%b want 1 1", magic, init_bus.rdy);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({init_bus.rdy, init_bus.rom, done, magic, overflow, miso, miso_oe} !== 15'h0) begin
         failures++; $display("FAIL rstmid_outputs got rdy=%b rom=%h done=%b magic=%b ovf=%b miso=%b oe=%b want all 0",
                              init_bus.rdy, init_bus.rom, done, magic, overflow, miso, miso_oe);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      cs_high();
      cs_low();
      spi_send(16'h0055, 16, mb);
      cs_high();
      for (int k = 0; k < 200 && init_bus.rdy !== 1'b1; k++) @(negedge clk);
      checks++;
      if (init_bus.rdy !== 1'b1 || init_bus.rom !== 9'h055) begin
         failures++; $display("FAIL rstmid_word got rdy=%b rom=%h want rdy=1 rom=055", init_bus.rdy, init_bus.rom);
      end
      init_bus.ack = 1'b1;
      @(negedge clk);
      init_bus.ack = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (init_bus.rdy !== 1'b0) begin failures++; $display("FAIL rstmid_stale got rdy=%b want 0", init_bus.rdy); end
   endtask

   initial begin
      init_bus.ack = 1'b0;
      test_reset();
      test_single_word();
      test_end_of_rom();
      test_magic();
      test_overflow();
      test_partial_word();
      test_back_to_back();
      test_reset_mid_word();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
